// File: rtl/ula_op_sequencer.sv
// Control sequencer for the ULA datapath: accepts one ALU command, loads the operands it
// needs into OP1/OP2, runs a single EXEC cycle, then holds the response until it is taken.
module ula_op_sequencer #(
  parameter int OP_WIDTH  = 4,
  parameter int SRC_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_WIDTH-1:0]  cmd_op,
  input  logic [SRC_WIDTH-1:0] cmd_src,
  input  logic                 cmd_jump,
  output logic                 opnd_req,
  output logic                 opnd_sel,
  input  logic                 opnd_valid,
  output logic                 ctrl_reg_op1,
  output logic                 ctrl_reg_op2,
  output logic [1:0]           sel_mux1,
  output logic [SRC_WIDTH-1:0] sel_mux2,
  output logic [OP_WIDTH-1:0]  sel_ula,
  output logic                 ctrl_reg_comp,
  output logic                 ctrl_reg_ovf,
  output logic                 rsp_valid,
  input  logic                 rsp_ready
);

  typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, EXEC, RESP} state_t;

  state_t               state_q, state_d;
  logic [OP_WIDTH-1:0]  op_q;
  logic [SRC_WIDTH-1:0] src_q;
  logic                 jump_q;

  // Ops 0101..1000 take only the B operand; 0100 and 1100 never read OP2.
  function automatic logic need_op1(input logic [OP_WIDTH-1:0] op, input logic jump);
    return !jump && !(op inside {OP_WIDTH'(5), OP_WIDTH'(6), OP_WIDTH'(7), OP_WIDTH'(8)});
  endfunction

  function automatic logic need_op2(input logic [OP_WIDTH-1:0] op, input logic [SRC_WIDTH-1:0] src);
    return (src == {SRC_WIDTH{1'b1}}) && !(op inside {OP_WIDTH'(4), OP_WIDTH'(12)});
  endfunction

  function automatic logic [1:0] mux1_sel(input logic [OP_WIDTH-1:0] op, input logic jump);
    if (jump)               return 2'b10;
    else if (need_op1(op, jump)) return 2'b11;
    else                    return 2'b00;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the command copy has no reset; it is only observed in states entered after a fresh accept.
  always_ff @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      op_q   <= cmd_op;
      src_q  <= cmd_src;
      jump_q <= cmd_jump;
    end
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    opnd_req      = 1'b0;
    opnd_sel      = 1'b0;
    ctrl_reg_op1  = 1'b0;
    ctrl_reg_op2  = 1'b0;
    sel_mux1      = 2'b00;
    sel_mux2      = '0;
    sel_ula       = '0;
    ctrl_reg_comp = 1'b0;
    ctrl_reg_ovf  = 1'b0;
    rsp_valid     = 1'b0;

    // While rst is high every output stays quiet, whatever state the flops still hold.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            if (need_op1(cmd_op, cmd_jump))     state_d = LOAD1;
            else if (need_op2(cmd_op, cmd_src)) state_d = LOAD2;
            else                                state_d = EXEC;
          end
        end
        LOAD1: begin
          opnd_req = 1'b1;
          if (opnd_valid) begin
            ctrl_reg_op1 = 1'b1;
            state_d      = need_op2(op_q, src_q) ? LOAD2 : EXEC;
          end
        end
        LOAD2: begin
          opnd_req = 1'b1;
          opnd_sel = 1'b1;
          if (opnd_valid) begin
            ctrl_reg_op2 = 1'b1;
            state_d      = EXEC;
          end
        end
        EXEC: begin
          sel_mux1      = mux1_sel(op_q, jump_q);
          sel_mux2      = src_q;
          sel_ula       = op_q;
          ctrl_reg_comp = op_q inside {OP_WIDTH'(9), OP_WIDTH'(10), OP_WIDTH'(11)};
          ctrl_reg_ovf  = op_q inside {OP_WIDTH'(0), OP_WIDTH'(1), OP_WIDTH'(2)};
          state_d       = RESP;
        end
        RESP: begin
          sel_mux1  = mux1_sel(op_q, jump_q);
          sel_mux2  = src_q;
          sel_ula   = op_q;
          rsp_valid = 1'b1;
          if (rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
